iir_out_capture: RTL and testbench
==================================

# iir_out_capture

Output-side capture buffer for the 6-stage cascaded SOS IIR filter top level. Records the filter's output sample stream (data, address, valid, done) into an on-chip 2048 × 16 memory. Tracks sample count, addressing errors and peak magnitude. After capture, it replays the stored block in order over a valid/ready stream for readback or checksum logic. It is the receiving end of the filter's `data_out`/`addr`/`data_out_valid`/`filter_done` interface, complementing the block that feeds `data_in`/`data_in_valid`.

## Interface

Parameters:
- `AW`, 11: address width; depth = 2^AW (2048).
- `DW`, 16: sample width, signed two's complement (Q1.15 from the filter).

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `arm`  in  1  single-cycle pulse; starts a new capture.
- `cap_data`  in  DW  filter output sample (`data_out`).
- `cap_addr`  in  AW  filter output index (`addr`).
- `cap_valid`  in  1  sample strobe (`data_out_valid`).
- `cap_done`  in  1  end-of-block flag from the filter (`filter_done`).
- `out_data`  out  DW  replayed sample.
- `out_valid`  out  1  replay data valid.
- `out_ready`  in  1  downstream accept.
- `out_last`  out  1  marks the final replayed sample.
- `busy`  out  1  high in CAPTURE or READ.
- `full`  out  1  sticky; 2^AW samples were captured this run.
- `seq_err`  out  1  sticky; a `cap_addr` did not match the expected index.
- `count`  out  AW+1  samples captured this run (0..2048).
- `peak_abs`  out  DW  maximum |sample| seen this run, saturated.

## Operation

- States: IDLE, CAPTURE, READ.
- IDLE:
  - `cap_valid` and `cap_done` are ignored.
  - `arm` → CAPTURE. The same edge clears `wr_ptr`, `count`, `full`, `seq_err` and `peak_abs`.
- CAPTURE:
  - Each `cap_valid` cycle writes `mem[cap_addr] <= cap_data`, then increments `wr_ptr` and `count`.
  - If `cap_addr != wr_ptr[AW-1:0]`, set `seq_err`. The write still goes to `cap_addr`; `wr_ptr` still increments.
  - Peak: abs(x) = x if x ≥ 0; otherwise −x, with 0x8000 saturating to 0x7FFF. `peak_abs <= max(peak_abs, abs)`.
  - Exit to READ when either:
    - the accepted sample brings `count` to 2^AW (`full` set on the same edge), or
    - `cap_done` is high (with or without `cap_valid`; a coincident sample is written and counted first).
  - If `count` is 0 at `cap_done`, go to IDLE instead.
  - `arm` in CAPTURE restarts the capture; counters clear as from IDLE. `arm` has priority over a coincident `cap_valid`, whose sample is dropped.
- READ:
  - Replays `mem[0..count-1]` in ascending order.
  - Memory read is synchronous, one-cycle latency. A one-entry output register holds data while `out_ready` is low.
  - `out_data` and `out_last` are stable while `out_valid && !out_ready`.
  - `out_last` = 1 only with the sample at index `count-1`.
  - When the handshake on the last sample completes → IDLE. `count`, `full`, `seq_err` and `peak_abs` hold until the next `arm`.
  - `arm`, `cap_valid` and `cap_done` are ignored in READ.
- Reset:
  - From any state, `rst` forces IDLE and zeros every output.
  - Memory contents are not cleared.
  - An in-flight replay is abandoned; `out_valid` drops on the next edge.

## Timing

- Reset values: `out_data`=0, `out_valid`=0, `out_last`=0, `busy`=0, `full`=0, `seq_err`=0, `count`=0, `peak_abs`=0; state = IDLE.
- `busy` rises the cycle after `arm` is sampled. It falls the cycle after the final READ handshake, or the cycle after the empty-done exit to IDLE.
- `count`, `peak_abs` and `seq_err` update on the edge that samples `cap_valid`, so they are visible the following cycle.
- Entry into READ occurs on the edge after the terminating sample or `cap_done`.
- First `out_valid` rises 2 cycles after READ entry (address issue, then RAM read).
- With `out_ready` held high, one sample transfers per cycle: throughput 1/clk, 2048 samples in 2048 cycles after the first.
- `out_ready` low stalls the read pipeline; no sample is lost or duplicated.
- `cap_valid` may be asserted every cycle; write throughput is 1/clk with no backpressure on the filter side.

## Test plan

- Reset, `arm`, then 2048 samples with `cap_addr` 0..2047 and data = index, `out_ready`=1 → `full`=1, `count`=2048, `seq_err`=0; replay 0x0000..0x07FF in order; `out_last` only on 0x07FF; `busy` drops after it.
- `arm`, 10 samples, then `cap_done` coincident with the 11th sample → `count`=11; 11 samples replayed; `full`=0.
- Samples 0x7000, 0x8000, 0xFFFF, 0x1234 → `peak_abs`=0x7FFF (saturated 0x8000).
- Addresses 0,1,3,4 → `seq_err`=1 from the cycle after the addr-3 write; replay of 4 entries returns mem[0..3] with mem[2] stale.
- Replay with `out_ready` toggling 1,0,0,1 → `out_data` held during stalls; no drop or duplicate; order preserved.
- Assert `rst` mid-replay → next cycle `out_valid`=0 and `busy`=0; `arm` then `cap_done` with no samples → return to IDLE, `count`=0, no `out_valid`.

Source files
------------

// File: rtl/iir_out_capture.sv
// iir_out_capture: records the IIR filter output stream into a 2^AW x DW
// memory, tracks count / address-sequence errors / saturated peak magnitude,
// then replays the captured block in order over a valid/ready stream.
module iir_out_capture #(
    parameter int AW = 11,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          arm,
    input  logic [DW-1:0] cap_data,
    input  logic [AW-1:0] cap_addr,
    input  logic          cap_valid,
    input  logic          cap_done,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_last,
    output logic          busy,
    output logic          full,
    output logic          seq_err,
    output logic [AW:0]   count,
    output logic [DW-1:0] peak_abs
);

    localparam int unsigned DEPTH_N = 1 << AW;
    localparam logic [AW:0] DEPTH   = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] ONE     = {{AW{1'b0}}, 1'b1};
    localparam logic [DW-1:0] NEG_MIN = {1'b1, {(DW-1){1'b0}}};
    localparam logic [DW-1:0] POS_MAX = {1'b0, {(DW-1){1'b1}}};

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        READ
    } state_t;

    state_t state, state_nxt;

    logic [DW-1:0] mem [0:DEPTH_N-1];

    logic [AW-1:0] wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [DW-1:0] ram_q;
    logic          ram_v;
    logic          ram_last;

    logic          wr_fire;
    logic [AW:0]   cnt_inc;
    logic [AW:0]   cnt_after;
    logic [DW-1:0] abs_x;
    logic          out_load;
    logic          rd_en;
    logic          read_entry;

    // Capture-side decode: accepted sample, post-write count, saturated |x|
    always_comb begin
        wr_fire   = (state == CAPTURE) && cap_valid && !arm;
        cnt_inc   = count + ONE;
        cnt_after = wr_fire ? cnt_inc : count;
        if (!cap_data[DW-1]) begin
            abs_x = cap_data;
        end else if (cap_data == NEG_MIN) begin
            abs_x = POS_MAX;
        end else begin
            abs_x = '0 - cap_data;
        end
    end

    // Read pipeline control: RAM stage advances only when the output register
    // can take its contents, so a stall backs up without losing a sample
    always_comb begin
        out_load   = ram_v && (!out_valid || out_ready);
        rd_en      = (state == READ) && (rd_ptr < count) && (!ram_v || out_load);
        read_entry = (state_nxt == READ) && (state != READ);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (arm) state_nxt = CAPTURE;
            end
            CAPTURE: begin
                if (arm) begin
                    state_nxt = CAPTURE;
                end else if (wr_fire && (cnt_inc == DEPTH)) begin
                    state_nxt = READ;
                end else if (cap_done) begin
                    state_nxt = (cnt_after == '0) ? IDLE : READ;
                end
            end
            READ: begin
                if (out_valid && out_ready && out_last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // Capture statistics: cleared by arm, updated on each accepted sample
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            seq_err  <= 1'b0;
            peak_abs <= '0;
        end else if (arm && (state != READ)) begin
            wr_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            seq_err  <= 1'b0;
            peak_abs <= '0;
        end else if (wr_fire) begin
            wr_ptr <= wr_ptr + 1'b1;
            count  <= cnt_inc;
            if (cnt_inc == DEPTH) full <= 1'b1;
            if (cap_addr != wr_ptr) seq_err <= 1'b1;
            if (abs_x > peak_abs) peak_abs <= abs_x;
        end
    end

    // Sample memory: write port from the filter, synchronous read for replay
    always_ff @(posedge clk) begin
        if (wr_fire && !rst) mem[cap_addr] <= cap_data;
        if (rd_en) ram_q <= mem[rd_ptr[AW-1:0]];
    end

    // Replay pipeline: address issue, RAM stage, one-entry output register
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr    <= '0;
            ram_v     <= 1'b0;
            ram_last  <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (read_entry) begin
            rd_ptr    <= '0;
            ram_v     <= 1'b0;
            ram_last  <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (state == READ) begin
            if (rd_en) begin
                rd_ptr   <= rd_ptr + ONE;
                ram_last <= (rd_ptr == (count - ONE));
                ram_v    <= 1'b1;
            end else if (out_load) begin
                ram_v <= 1'b0;
            end
            if (out_load) begin
                out_valid <= 1'b1;
                out_data  <= ram_q;
                out_last  <= ram_last;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end else begin
            ram_v     <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_iir_out_capture.sv
// Self-checking bench for iir_out_capture: randomized capture blocks checked
// against an array/arithmetic reference of the capture and replay rules.
module tb_iir_out_capture;

    localparam int AW = 11;
    localparam int DW = 16;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          arm;
    logic [DW-1:0] cap_data;
    logic [AW-1:0] cap_addr;
    logic          cap_valid;
    logic          cap_done;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic          busy;
    logic          full;
    logic          seq_err;
    logic [AW:0]   count;
    logic [DW-1:0] peak_abs;

    iir_out_capture #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst), .arm(arm),
        .cap_data(cap_data), .cap_addr(cap_addr), .cap_valid(cap_valid), .cap_done(cap_done),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .busy(busy), .full(full), .seq_err(seq_err), .count(count), .peak_abs(peak_abs)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // reference model state
    int ref_mem [DEPTH];
    int m_count;
    int m_peak;
    bit m_seq;
    int m_idx;

    // per-block stimulus
    int stim_addr [DEPTH];
    int stim_data [DEPTH];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sat_abs(input int d);
        logic signed [DW-1:0] s;
        int v;
        s = d[DW-1:0];
        v = s;
        if (v < 0) v = -v;
        if (v > 32767) v = 32767;
        return v;
    endfunction

    task automatic model_clear();
        m_count = 0;
        m_peak  = 0;
        m_seq   = 0;
        m_idx   = 0;
    endtask

    task automatic arm_pulse();
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
        model_clear();
        check("busy_after_arm", {31'd0, busy}, 32'd1);
        check("count_after_arm", {20'd0, count}, 32'd0);
    endtask

    // drive n samples from stim_*; optional idle gaps; done coincident with last
    // sample or as a separate cycle (skipped when the block filled the memory)
    task automatic run_capture(input int n, input bit done_last, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps && ($urandom_range(0, 3) == 0)) begin
                cap_valid = 1'b0;
                @(negedge clk);
            end
            cap_valid = 1'b1;
            cap_addr  = stim_addr[i][AW-1:0];
            cap_data  = stim_data[i][DW-1:0];
            cap_done  = done_last && (i == n - 1);
            @(negedge clk);
            cap_valid = 1'b0;
            cap_done  = 1'b0;
            ref_mem[stim_addr[i]] = stim_data[i] & 32'hFFFF;
            if (stim_addr[i] != (m_idx % DEPTH)) m_seq = 1;
            m_idx++;
            m_count++;
            if (sat_abs(stim_data[i]) > m_peak) m_peak = sat_abs(stim_data[i]);
            check("count", {20'd0, count}, m_count);
            check("peak_abs", {16'd0, peak_abs}, m_peak);
            check("seq_err", {31'd0, seq_err}, {31'd0, m_seq});
        end
        if (!done_last && m_count < DEPTH) begin
            cap_done = 1'b1;
            @(negedge clk);
            cap_done = 1'b0;
        end
        check("full", {31'd0, full}, (m_count == DEPTH) ? 32'd1 : 32'd0);
    endtask

    // mode 0: ready always high; 1: pattern 1,0,0,1; 2: random
    task automatic run_replay(input int mode);
        int  idx = 0;
        int  waits = 0;
        bit  seen = 0;
        bit  held_pending = 0;
        logic [DW-1:0] held = '0;
        bit  rdy;
        int  k = 0;
        bit  done = 0;
        for (int cyc = 0; cyc < 5 * m_count + 20 && !done; cyc++) begin
            case (mode)
                0: rdy = 1'b1;
                1: rdy = (k % 4 == 0) || (k % 4 == 3);
                default: rdy = ($urandom_range(0, 1) == 1);
            endcase
            k++;
            out_ready = rdy;
            if (out_valid) begin
                if (!seen) begin
                    seen = 1;
                    check("first_valid_latency", waits, 32'd2);
                end
                if (held_pending) check("stall_hold", {16'd0, out_data}, {16'd0, held});
                if (rdy) begin
                    check("replay_data", {16'd0, out_data}, ref_mem[idx]);
                    check("replay_last", {31'd0, out_last}, (idx == m_count - 1) ? 32'd1 : 32'd0);
                    held_pending = 0;
                    idx++;
                    if (idx == m_count || out_last) done = 1;
                end else begin
                    held_pending = 1;
                    held = out_data;
                end
            end else begin
                if (!seen) waits++;
                if (held_pending) check("valid_dropped_in_stall", 32'd0, 32'd1);
            end
            if (!done) @(negedge clk);
        end
        if (!done) check("replay_timeout", idx, m_count);
        check("replay_count", idx, m_count);
        @(negedge clk);
        out_ready = 1'b0;
        check("busy_after_replay", {31'd0, busy}, 32'd0);
        check("valid_after_replay", {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        int n;
        rst = 1'b1; arm = 1'b0; cap_valid = 1'b0; cap_done = 1'b0;
        cap_addr = '0; cap_data = '0; out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 0;
        model_clear();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_out_data", {16'd0, out_data}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_last", {31'd0, out_last}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_full", {31'd0, full}, 32'd0);
        check("rst_seq_err", {31'd0, seq_err}, 32'd0);
        check("rst_count", {20'd0, count}, 32'd0);
        check("rst_peak", {16'd0, peak_abs}, 32'd0);

        // full-depth block, data = index
        arm_pulse();
        for (int i = 0; i < DEPTH; i++) begin
            stim_addr[i] = i;
            stim_data[i] = i;
        end
        run_capture(DEPTH, 0, 0);
        check("full_count", {20'd0, count}, DEPTH);
        run_replay(0);

        // 10 samples then done coincident with the 11th
        arm_pulse();
        for (int i = 0; i < 11; i++) begin
            stim_addr[i] = i;
            stim_data[i] = $urandom_range(0, 65535);
        end
        run_capture(11, 1, 0);
        check("count_11", {20'd0, count}, 32'd11);
        run_replay(0);

        // saturated peak
        arm_pulse();
        stim_addr[0] = 0; stim_data[0] = 32'h7000;
        stim_addr[1] = 1; stim_data[1] = 32'h8000;
        stim_addr[2] = 2; stim_data[2] = 32'hFFFF;
        stim_addr[3] = 3; stim_data[3] = 32'h1234;
        run_capture(4, 0, 0);
        check("peak_sat", {16'd0, peak_abs}, 32'h7FFF);
        run_replay(1);

        // address skip: 0,1,3,4 leaves mem[2] stale
        arm_pulse();
        stim_addr[0] = 0; stim_addr[1] = 1; stim_addr[2] = 3; stim_addr[3] = 4;
        for (int i = 0; i < 4; i++) stim_data[i] = $urandom_range(0, 65535);
        run_capture(4, 0, 0);
        check("seq_err_skip", {31'd0, seq_err}, 32'd1);
        run_replay(2);

        // randomized blocks
        for (int r = 0; r < 8; r++) begin
            arm_pulse();
            n = $urandom_range(1, 40);
            for (int i = 0; i < n; i++) begin
                stim_addr[i] = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 60) : i;
                stim_data[i] = $urandom_range(0, 65535);
            end
            run_capture(n, $urandom_range(0, 1) == 1, 1);
            run_replay(2);
        end

        // reset mid-replay, then empty done
        arm_pulse();
        for (int i = 0; i < 20; i++) begin
            stim_addr[i] = i;
            stim_data[i] = $urandom_range(0, 65535);
        end
        run_capture(20, 0, 0);
        out_ready = 1'b1;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b0;
        model_clear();
        check("midrst_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_count", {20'd0, count}, 32'd0);
        check("midrst_peak", {16'd0, peak_abs}, 32'd0);
        arm_pulse();
        cap_done = 1'b1;
        @(negedge clk);
        cap_done = 1'b0;
        check("empty_done_busy", {31'd0, busy}, 32'd0);
        check("empty_done_count", {20'd0, count}, 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("empty_done_no_valid", {31'd0, out_valid}, 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
